// File: rtl/wb_sram_banked.sv
// Banked Wishbone classic slave RAM with configurable read latency and error response for unpopulated banks.
// Define WB_SRAM_BANKED_INIT_EN to fill every word with INIT_VALUE after reset before serving the bus.
module wb_sram_banked #(
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 1024,
    parameter int                 BANKS      = 2,
    parameter int                 RD_LAT     = 1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0,
    localparam int                WW         = $clog2(DEPTH),
    localparam int                BW         = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int                AW         = WW + BW
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [AW-1:0]         adr_i,
    input  logic [DATA_W-1:0]     dat_i,
    output logic [DATA_W-1:0]     dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  init_done_o
);

    localparam int         NB       = DATA_W / 8;
    localparam int         PL       = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam logic [1:0] CNT_LOAD = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

`ifdef WB_SRAM_BANKED_INIT_EN
    typedef enum logic [1:0] {IDLE, RD, RESP, INIT} state_t;
    localparam state_t RST_STATE = INIT;
`else
    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                         r_state, w_state_nxt;
    logic [1:0]                     r_cnt, w_cnt_nxt;
    logic                           w_req, w_bank_ok, w_wr_en;
    logic                           w_ack_nxt, w_err_nxt, w_dat_ld;
    logic [WW-1:0]                  w_word;
    logic [BW-1:0]                  w_bank;
    logic [BANKS-1:0][DATA_W-1:0]   w_bank_rd;
    logic [DATA_W-1:0]              w_rd_data, w_ld_data, r_dat;
    logic [DATA_W-1:0]              r_pipe [PL];
    logic                           r_ack, r_err;

`ifdef WB_SRAM_BANKED_INIT_EN
    logic [WW-1:0]                  r_init_cnt;
    logic                           r_init_done;
    logic                           w_init_wr;
`endif

    assign w_req     = cyc_i & stb_i;
    assign w_word    = adr_i[WW-1:0];
    assign w_bank    = adr_i[AW-1:WW];
    assign w_bank_ok = ({1'b0, w_bank} < (BW+1)'(BANKS));

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic              w_sel;

        assign w_sel = (w_bank == BW'(b));

        // NOTE: the storage array has no reset branch so it maps onto an SRAM macro; contents survive rst_ni.
        always_ff @(posedge clk_i) begin
`ifdef WB_SRAM_BANKED_INIT_EN
            if (w_init_wr) begin
                r_mem[r_init_cnt] <= INIT_VALUE;
            end else
`endif
            if (w_wr_en && w_sel) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_i[k]) r_mem[w_word][8*k +: 8] <= dat_i[8*k +: 8];
                end
            end
        end

        assign w_bank_rd[b] = r_mem[w_word];
    end

    always_comb begin
        w_rd_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_bank == BW'(b)) w_rd_data = w_bank_rd[b];
        end
    end

    // Slot 0 captures the bank output at the issue edge; later slots only shift it toward dat_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PL; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_rd_data;
            for (int i = 1; i < PL; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_ld_data = (RD_LAT == 1) ? w_rd_data : r_pipe[PL-1];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_ld    = 1'b0;
`ifdef WB_SRAM_BANKED_INIT_EN
        w_init_wr   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_bank_ok) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = RESP;
                    end else if (we_i) begin
                        w_wr_en     = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = RESP;
                    end else if (RD_LAT == 1) begin
                        w_dat_ld    = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = RD;
                    end
                end
            end
            RD: begin
                if (!cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 2'd0) begin
                    w_dat_ld    = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 2'd1;
                end
            end
            RESP: w_state_nxt = IDLE;
`ifdef WB_SRAM_BANKED_INIT_EN
            INIT: begin
                w_init_wr = 1'b1;
                if (r_init_cnt == WW'(DEPTH - 1)) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RST_STATE;
            r_cnt   <= 2'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (w_dat_ld) r_dat <= w_ld_data;
        end
    end

`ifdef WB_SRAM_BANKED_INIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (w_init_wr) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == WW'(DEPTH - 1)) r_init_done <= 1'b1;
        end
    end

    assign init_done_o = r_init_done;
`else
    assign init_done_o = rst_ni;
`endif

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign dat_o = r_dat;

endmodule
